addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
Parametrised, pipelined two's-complement add/subtract unit. It is the next-generation replacement for the 8-bit combinational add/sub block.
- Operands are split into STAGES equal slices, one slice computed per stage, with the carry registered between stages.
- A valid/ready stream interface sits on each side, so it drops into datapaths that have back-pressure.
- Sits between operand-fetch logic and the result writeback stage.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES; minimum 2.
STAGES, 4, number of pipeline stages (slices) = latency in cycles; 1..WIDTH.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand transfer request.
in_ready  output  1  unit can accept operands this cycle.
x  input  WIDTH  operand X.
y  input  WIDTH  operand Y.
mode  input  1  1 = add (MODE_ADD), 0 = subtract (MODE_SUB).
carry_in  input  1  add: carry-in; sub: not-borrow-in (drive 1 for plain X-Y).
out_valid  output  1  result available.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result.
carry_out  output  1  add: carry; sub: 1 = no borrow.
ovf  output  1  signed overflow.

Behaviour:
- Arithmetic: Y' = y when mode=1, ~y when mode=0. Full result = x + Y' + carry_in over WIDTH+1 bits, so subtract is x + ~y + carry_in. sum = low WIDTH bits; carry_out = bit WIDTH.
- ovf = (x[MSB] == Y'[MSB]) && (sum[MSB] != x[MSB]).
- Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Global advance: adv = out_ready || !out_valid. in_ready = adv, combinational from out_ready and the valid register. No combinational path from in_valid to in_ready.
- Pipeline register contents per stage:
  - valid bit;
  - registered carry;
  - completed low slices of sum;
  - remaining unprocessed slices of x and Y';
  - MSB sign bits of x and Y' for ovf.
- Stage k computes slice k bits [k*W/S +: W/S] using the carry from stage k-1; stage 0 uses carry_in.
- When adv=1 every stage shifts forward by one, and stage 0 loads on input transfer (valid=0 otherwise). When adv=0 all stages hold.
- Bubbles are not collapsed: throughput is 1 result/cycle when out_ready is held high.
- Latency: an operand accepted at edge N gives out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages. STAGES=1 gives 1-cycle latency.
- Outputs sum, carry_out and ovf are registered and stable while out_valid && !out_ready.
- Ordering: results emerge in acceptance order; none are dropped or duplicated.
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - all valid bits 0, so out_valid=0 immediately;
  - sum=0, carry_out=0, ovf=0;
  - in-flight operations are discarded.
  - in_ready=1 after reset.
- Boundaries:
  - 0xFFFF+0x0001 wraps to 0x0000 with carry_out=1.
  - 0x0000-0x0000 (carry_in=1) gives 0x0000 with carry_out=1.
  - Simultaneous output and input transfer in a full pipeline is allowed.
  - mode and carry_in are sampled only at input transfer.

Optional Feature:
ADDSUB_SAT_EN:
- Defined: on ovf=1, sum saturates to the signed extreme: 0 1...1 if x[MSB]=0, 1 0...0 if x[MSB]=1. ovf is still reported; carry_out still reflects the unsaturated result.
- Undefined: sum wraps (modular); ovf is a flag only.
- The saturation mux sits in the final stage only; latency is unchanged.

Decomposition:
- Package addsub_pkg:
  - MODE_ADD = 1'b1 and MODE_SUB = 1'b0 localparams;
  - helper function computing slice width (WIDTH/STAGES);
  - sat_max/sat_min constant functions.
- Sub-module addsub_slice: combinational W/S-bit ripple adder (a, b, cin -> s, cout), instantiated STAGES times via generate.
- Pipeline registers, handshake logic and the ovf/saturation logic stay in addsub_pipe.

Test Plan:
All scenarios use WIDTH=16, STAGES=4.
- Add: x=0x00FF, y=0x0001, mode=1, carry_in=0 -> sum=0x0100, carry_out=0, ovf=0, out_valid exactly 4 cycles after accept.
- Subtract: x=0x0005, y=0x0007, mode=0, carry_in=1 -> sum=0xFFFE, carry_out=0 (borrow), ovf=0. x=0x0007, y=0x0005 -> 0x0002, carry_out=1.
- Signed overflow: x=0x7FFF, y=0x0001, add -> ovf=1; sum=0x8000 without ADDSUB_SAT_EN, 0x7FFF with it. x=0x8000, y=0x0001, sub -> ovf=1; 0x7FFF wrap / 0x8000 saturated.
- Streaming: 8 back-to-back operand pairs with out_ready=1 -> 8 consecutive out_valid cycles, first at cycle 4, correct values in order.
- Back-pressure: stream 6 operands, drop out_ready for 3 cycles mid-stream -> in_ready=0 while out_valid && !out_ready, held output stable, all 6 results correct and in order.
- Reset mid-operation: 3 operations in flight, assert rst_n=0 asynchronously between edges -> out_valid=0 immediately, sum=0. After release, no stale results appear and in_ready=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    // Bits handled by each pipeline stage
    function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Offset of stage k's leftover-operand segment inside a triangular flat vector:
    // stage j keeps (stages-1-j) slices that later stages still need.
    function automatic int unsigned rem_offset(input int unsigned stages, input int unsigned sw,
                                               input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < k; j++) begin
            off += (stages - 1 - j) * sw;
        end
        return off;
    endfunction

    // Largest positive signed value of the given width (0 1...1)
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative signed value of the given width (1 0...0)
    function automatic logic [63:0] sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One ripple slice of the pipelined adder: s/cout = a + b + cin.
module addsub_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout
);

    localparam int unsigned SW1 = SW + 1;

    assign {cout, s} = SW1'(a) + SW1'(b) + SW1'(cin);

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract unit with valid/ready on both sides.
// One WIDTH/STAGES-bit slice per stage, carry registered between stages.
// Optional macro ADDSUB_SAT_EN: saturate sum to the signed extreme on overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             mode,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf
);

    localparam int unsigned SW   = slice_width(WIDTH, STAGES);
    localparam int unsigned MIDS = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int unsigned YT   = rem_offset(STAGES, SW, STAGES - 1);
    localparam int unsigned YTW  = (YT > 0) ? YT : 1;

    logic             adv;
    logic             acc;
    logic [WIDTH-1:0] yp;

    // Intermediate stages 0..STAGES-2. p holds {finished sum slices, unprocessed x slices},
    // so it stays WIDTH bits wide as slices of x are replaced by slices of sum.
    logic [MIDS-1:0]            v_q, v_d, c_q, c_d;
    logic [MIDS-1:0][WIDTH-1:0] p_q, p_d;
    logic [YTW-1:0]             yr_q, yr_d;

    logic [STAGES-1:0][SW-1:0] sa, sb, ss;
    logic [STAGES-1:0]         sci, sco;

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_v;
    logic             fin_xm;
    logic             fin_ym;
    logic             fin_ovf;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;
    assign acc      = in_valid && adv;
    assign yp       = (mode == MODE_ADD) ? y : ~y;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_slice #(.SW(SW)) u_slice (
            .a   (sa[k]),
            .b   (sb[k]),
            .cin (sci[k]),
            .s   (ss[k]),
            .cout(sco[k])
        );

        // Slice operands: straight from the ports for stage 0, else from the previous stage
        if (k == 0) begin : g_src
            assign sa[k]  = x[SW-1:0];
            assign sb[k]  = yp[SW-1:0];
            assign sci[k] = carry_in;
        end else begin : g_src
            localparam int unsigned PO = rem_offset(STAGES, SW, k - 1);
            assign sa[k]  = p_q[k-1][SW-1:0];
            assign sb[k]  = yr_q[PO +: SW];
            assign sci[k] = c_q[k-1];
        end

        if (k < STAGES - 1) begin : g_mid
            localparam int unsigned YO = rem_offset(STAGES, SW, k);
            localparam int unsigned RW = (STAGES - 1 - k) * SW;
            if (k == 0) begin : g_ld
                assign v_d[k]          = acc;
                assign p_d[k]          = {ss[k], x[WIDTH-1:SW]};
                assign yr_d[YO +: RW]  = yp[WIDTH-1:SW];
            end else begin : g_ld
                localparam int unsigned PO = rem_offset(STAGES, SW, k - 1);
                assign v_d[k]          = v_q[k-1];
                assign p_d[k]          = {ss[k], p_q[k-1][WIDTH-1:SW]};
                assign yr_d[YO +: RW]  = yr_q[PO + SW +: RW];
            end
            assign c_d[k] = sco[k];
        end else begin : g_fin
            if (k == 0) begin : g_ld
                assign fin_v   = acc;
                assign raw_sum = ss[k];
            end else begin : g_ld
                assign fin_v   = v_q[k-1];
                assign raw_sum = {ss[k], p_q[k-1][WIDTH-1:SW]};
            end
        end
    end

    // The top slice carries the operand sign bits
    assign fin_xm  = sa[STAGES-1][SW-1];
    assign fin_ym  = sb[STAGES-1][SW-1];
    assign fin_ovf = (fin_xm == fin_ym) && (raw_sum[WIDTH-1] != fin_xm);

`ifdef ADDSUB_SAT_EN
    assign fin_sum = !fin_ovf ? raw_sum
                   : (fin_xm ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH)));
`else
    assign fin_sum = raw_sum;
`endif

    // Whole pipeline shifts together on adv, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            c_q       <= '0;
            p_q       <= '0;
            yr_q      <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            v_q       <= v_d;
            c_q       <= c_d;
            p_q       <= p_d;
            yr_q      <= yr_d;
            out_valid <= fin_v;
            sum       <= fin_sum;
            carry_out <= sco[STAGES-1];
            ovf       <= fin_ovf;
        end
    end

endmodule
